// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: request sequencer for a single-port byte memory.
// Takes one read/write request at a time on a valid/ready port and issues one
// memory command per request. Reads wait the memory's registered latency and
// return data on a valid/ready response port. The controller also range-checks
// addresses and counts completed accesses and address errors.
module mem_access_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 11,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

  // Wait counter counts down from RD_LAT-1 to 0 while in WAIT.
  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_LAT - 1);
  // One extra bit so DEPTH == 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept;
  logic              in_range;

  // req_ready is only ever high in IDLE, so this is the acceptance handshake.
  assign accept   = (state == IDLE) & req_ready & req_valid;
  assign in_range = {1'b0, req_addr} < DEPTH_C;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic and strobes decoded purely from the state register.
  // NOTE: every output gets a default first, so no path through the case can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!in_range) next_state = req_wr ? IDLE : RESP;
          else           next_state = req_wr ? WRITE : READ;
        end
      end
      WRITE: begin
        mem_wr     = 1'b1;
        next_state = IDLE;
      end
      READ: begin
        mem_rd     = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) next_state = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // req_ready is registered so it is low in the reset cycle even though the
  // state register already reads IDLE then.
  always_ff @(posedge clk) begin
    if (rst) req_ready <= 1'b0;
    else     req_ready <= (next_state == IDLE);
  end

  // Request capture, read-latency timer, response registers and counters.
  // NOTE: the datapath registers are reset too, because a reset mid-operation
  // must drop the pending response and clear the visible counters and address.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      wait_cnt  <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      err_cnt   <= '0;
    end else begin
      if (accept) begin
        mem_addr  <= req_addr;
        mem_wdata <= req_wdata;
        if (!in_range) begin
          err_cnt <= err_cnt + 1'b1;
          if (!req_wr) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end
        end
      end
      if (state == WRITE) wr_cnt <= wr_cnt + 1'b1;
      if (state == READ) wait_cnt <= WAIT_LOAD;
      if (state == WAIT) begin
        if (wait_cnt == '0) begin
          resp_data <= mem_rdata;
          resp_err  <= 1'b0;
          rd_cnt    <= rd_cnt + 1'b1;
        end else begin
          wait_cnt <= wait_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: a RD_LAT=1 instance against a behavioural
// byte memory, and a RD_LAT=3 instance whose read data changes every cycle
// so the capture cycle is visible.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RD_LAT = 1 instance ----------------
  logic        req_valid = 0, req_wr = 0, resp_ready = 0;
  logic [3:0]  req_addr = 0;
  logic [7:0]  req_wdata = 0;
  logic        req_ready, resp_valid, resp_err, mem_wr, mem_rd;
  logic [7:0]  resp_data, mem_wdata, mem_rdata;
  logic [3:0]  mem_addr;
  logic [15:0] wr_cnt, rd_cnt, err_cnt;

  mem_access_ctrl #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt)
  );

  // Byte memory with one-cycle registered read; 0xEE when no read was issued.
  logic [7:0] mem [16];
  initial foreach (mem[i]) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_rd ? mem[mem_addr] : 8'hEE;
  end

  // ---------------- RD_LAT = 3 instance ----------------
  logic        req_valid3 = 0, resp_ready3 = 0;
  logic [3:0]  req_addr3 = 0;
  logic        req_ready3, resp_valid3, resp_err3, mem_wr3, mem_rd3;
  logic [7:0]  resp_data3, mem_wdata3, mem_rdata3;
  logic [3:0]  mem_addr3;
  logic [15:0] wr_cnt3, rd_cnt3, err_cnt3;

  assign mem_rdata3 = 8'(cyc) ^ 8'h5A;

  mem_access_ctrl #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_wr(1'b0),
    .req_addr(req_addr3), .req_wdata(8'h00),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3),
    .resp_data(resp_data3), .resp_err(resp_err3),
    .mem_wr(mem_wr3), .mem_rd(mem_rd3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .wr_cnt(wr_cnt3), .rd_cnt(rd_cnt3), .err_cnt(err_cnt3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       err;    // expected resp_err / out-of-range
    logic [7:0] rdata;  // expected resp_data for reads
  } vec_t;

  // Drives one request on dut1 from IDLE and follows it to completion.
  task automatic do_vec(input vec_t v);
    req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    check("vec req_ready idle", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    if (v.wr && !v.err) begin
      check("wr mem_wr", 32'(mem_wr), 32'd1);
      check("wr mem_rd", 32'(mem_rd), 32'd0);
      check("wr mem_addr", 32'(mem_addr), 32'(v.addr));
      check("wr mem_wdata", 32'(mem_wdata), 32'(v.wdata));
      tick();
      check("wr done mem_wr", 32'(mem_wr), 32'd0);
      check("wr done req_ready", 32'(req_ready), 32'd1);
    end else if (v.wr) begin
      check("bad wr no strobe", 32'({mem_wr, mem_rd}), 32'd0);
      check("bad wr req_ready", 32'(req_ready), 32'd1);
    end else begin
      if (!v.err) begin
        check("rd mem_rd", 32'(mem_rd), 32'd1);
        check("rd mem_addr", 32'(mem_addr), 32'(v.addr));
        tick();
        check("rd wait quiet", 32'({mem_wr, mem_rd, resp_valid}), 32'd0);
        tick();
      end else begin
        check("bad rd no strobe", 32'({mem_wr, mem_rd}), 32'd0);
      end
      check("rd resp_valid", 32'(resp_valid), 32'd1);
      check("rd resp_err", 32'(resp_err), 32'(v.err));
      check("rd resp_data", 32'(resp_data), 32'(v.rdata));
      check("rd req_ready busy", 32'(req_ready), 32'd0);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("rd resp dropped", 32'(resp_valid), 32'd0);
      check("rd back idle", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    vec_t vecs[9];
    int   t0;
    logic [7:0] exp3;
    int   sb_wr, sb_rd, sb_err, n_req, cycles;
    logic scored;

    vecs[0] = '{1'b1, 4'd3,  8'hA5, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 4'd3,  8'h00, 1'b0, 8'hA5};
    vecs[2] = '{1'b1, 4'd11, 8'h77, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 4'd15, 8'h00, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 4'd0,  8'h3C, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 4'd10, 8'hFF, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 4'd10, 8'h00, 1'b0, 8'hFF};
    vecs[7] = '{1'b0, 4'd0,  8'h00, 1'b0, 8'h3C};
    vecs[8] = '{1'b0, 4'd11, 8'h00, 1'b1, 8'h00};

    // Reset state.
    tick(); tick();
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst strobes", 32'({mem_wr, mem_rd, resp_valid}), 32'd0);
    check("rst counters", 32'(wr_cnt | rd_cnt | err_cnt), 32'd0);
    check("rst mem_addr/data", 32'({mem_addr, mem_wdata, resp_data, resp_err}), 32'd0);
    rst = 1'b0;
    tick();
    check("post rst req_ready", 32'(req_ready), 32'd1);
    check("post rst req_ready3", 32'(req_ready3), 32'd1);

    // Table of directed requests.
    foreach (vecs[i]) do_vec(vecs[i]);
    check("tbl wr_cnt", 32'(wr_cnt), 32'd3);
    check("tbl rd_cnt", 32'(rd_cnt), 32'd3);
    check("tbl err_cnt", 32'(err_cnt), 32'd3);

    // Response back-pressure: held stable while resp_ready stays low.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd3;
    tick(); req_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("bp resp_valid", 32'(resp_valid), 32'd1);
      check("bp resp_data", 32'(resp_data), 32'hA5);
      check("bp req_ready", 32'(req_ready), 32'd0);
      if (i < 4) tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp released", 32'({resp_valid, req_ready}), 32'b01);
    check("bp rd_cnt", 32'(rd_cnt), 32'd4);

    // RD_LAT=3: data captured from the cycle T+4, response at T+5.
    req_valid3 = 1'b1; req_addr3 = 4'd0;
    t0 = cyc;
    exp3 = 8'(t0 + 4) ^ 8'h5A;
    tick(); req_valid3 = 1'b0;
    check("lat3 mem_rd T+1", 32'(mem_rd3), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("lat3 wait quiet", 32'({mem_rd3, resp_valid3}), 32'd0);
    end
    tick();
    check("lat3 resp_valid T+5", 32'(resp_valid3), 32'd1);
    check("lat3 resp_data", 32'(resp_data3), 32'(exp3));
    check("lat3 resp_err", 32'(resp_err3), 32'd0);
    resp_ready3 = 1'b1;
    tick();
    resp_ready3 = 1'b0;
    check("lat3 rd_cnt", 32'(rd_cnt3), 32'd1);

    // Reset during WAIT on dut3 and during RESP on dut1.
    req_valid3 = 1'b1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd10;
    tick(); req_valid3 = 1'b0; req_valid = 1'b0;
    tick(); tick();
    check("pre-rst dut1 in RESP", 32'(resp_valid), 32'd1);
    check("pre-rst dut3 waiting", 32'(resp_valid3), 32'd0);
    rst = 1'b1;
    tick();
    check("mid rst resp_valid", 32'({resp_valid, resp_valid3}), 32'd0);
    check("mid rst strobes", 32'({mem_wr, mem_rd, mem_wr3, mem_rd3}), 32'd0);
    check("mid rst counters", 32'(wr_cnt | rd_cnt | err_cnt | rd_cnt3), 32'd0);
    check("mid rst req_ready", 32'({req_ready, req_ready3}), 32'd0);
    rst = 1'b0;
    tick();
    check("after rst req_ready", 32'({req_ready, req_ready3}), 32'b11);
    check("after rst no strobe", 32'({mem_wr, mem_rd, mem_wr3, mem_rd3, resp_valid, resp_valid3}), 32'd0);

    // Back-to-back random requests with req_valid held high.
    sb_wr = 0; sb_rd = 0; sb_err = 0; n_req = 0; cycles = 0;
    resp_ready = 1'b1;
    req_wr = 1'($urandom_range(0, 1));
    req_addr = 4'($urandom_range(0, 15));
    req_wdata = 8'($urandom_range(0, 255));
    req_valid = 1'b1;
    while (n_req < 20 && cycles < 400) begin
      check("b2b wr&rd exclusive", 32'(mem_wr & mem_rd), 32'd0);
      check("b2b single outstanding", 32'(req_ready & (mem_wr | mem_rd | resp_valid)), 32'd0);
      scored = 1'b0;
      if (req_ready) begin
        if (req_addr >= 4'd11) sb_err++;
        else if (req_wr) sb_wr++;
        else sb_rd++;
        n_req++;
        scored = 1'b1;
      end
      tick();
      cycles++;
      if (scored) begin
        if (n_req == 20) req_valid = 1'b0;
        else begin
          req_wr = 1'($urandom_range(0, 1));
          req_addr = 4'($urandom_range(0, 15));
          req_wdata = 8'($urandom_range(0, 255));
        end
      end
    end
    while (!req_ready && cycles < 400) begin
      tick();
      cycles++;
    end
    check("b2b within budget", 32'(cycles < 400), 32'd1);
    resp_ready = 1'b0;
    check("b2b wr_cnt", 32'(wr_cnt), 32'(sb_wr));
    check("b2b rd_cnt", 32'(rd_cnt), 32'(sb_rd));
    check("b2b err_cnt", 32'(err_cnt), 32'(sb_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
